panda_dbus_arbiter: RTL
=======================

# panda_dbus_arbiter

Two-master AXI-Lite arbiter sharing the single peripheral data path (AXI-APB bridge and the APB-GPIO/I2C/TIMER/UART peripherals) between the RISC-V core data bus (master 0) and a second bus master such as a DMA or debug port (master 1). It grants whole transactions round-robin and keeps exactly one transaction (read or write) outstanding at a time, which matches the serial APB side. Its output connects directly to the bridge's AXI-Lite slave port.

## Interface
- `addr_width`, default 32: address width of all AR/AW channels.
- `data_width`, default 32: data width; strobe width is `data_width/8`.
- `simulation_delay`, default 0: delay applied to register updates in simulation only.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high. One clock domain.
- `s{n}_axi_araddr / arvalid / arready`  in/in/out  addr_width/1/1  master n read address, n = 0 or 1.
- `s{n}_axi_rdata / rresp / rvalid / rready`  out/out/out/in  data_width/2/1/1  master n read data.
- `s{n}_axi_awaddr / awvalid / awready`  in/in/out  addr_width/1/1  master n write address.
- `s{n}_axi_wdata / wstrb / wvalid / wready`  in/in/in/out  data_width/strb/1/1  master n write data.
- `s{n}_axi_bresp / bvalid / bready`  out/out/in  2/1/1  master n write response.
- `m_axi_*`  mirror of the above toward the bridge, with directions reversed; `m_axi_arprot` and `m_axi_awprot` are tied to 3'b000.
- `grant`  out  2  one-hot owner of the current transaction; 2'b00 when idle.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- State machine states:
  - IDLE
  - RD_A: address phase of a read.
  - RD_D: data phase of a read.
  - WR_AW: combined AW/W phase of a write.
  - WR_B: response phase of a write.
- Request definition: master n requests when `arvalid | awvalid`.
- Arbitration in IDLE:
  - Round-robin on register `last`. The master other than `last` wins if it requests; otherwise the requesting master wins.
  - Winner n sets `grant[n]` and `last <= n`.
  - If the winner's `awvalid` is high, the next state is WR_AW; otherwise it is RD_A. Within one master, write has priority over read.
- RD_A:
  - `m_axi_araddr/arvalid` = the granted master's signals. The granted master's `arready` = `m_axi_arready`.
  - On handshake, go to RD_D.
- RD_D:
  - The granted master's `rdata/rresp/rvalid` = the bridge's. `m_axi_rready` = the granted master's `rready`.
  - On handshake, go to IDLE.
- WR_AW:
  - AW and W are forwarded independently.
  - Flags `aw_done` and `w_done` are set on each handshake. The corresponding valid toward the bridge is masked once its flag is set.
  - When both flags are set (a same-cycle handshake counts), clear both flags and go to WR_B.
- WR_B: forward B to the granted master. On handshake, go to IDLE.
- The non-granted master sees all of its readies and valids at 0. Its requests stay pending; AXI valid-hold is relied upon.
- Masters are never aborted. There is no timeout here; the core's dbus timeout covers a hung bridge.

## Timing
- Reset values:
  - state = IDLE.
  - `grant` = 00, `busy` = 0, `last` = 1, so master 0 wins the first contention.
  - `aw_done` = `w_done` = 0.
  - All `m_axi` valids, all `s` readies and all `s` response valids are 0.
- Asserting reset mid-transaction returns the block to IDLE immediately. The outstanding bridge transaction is abandoned; the bridge is reset by the same system reset.
- Latency:
  - Grant is registered: a request seen in IDLE at edge k reaches `m_axi` valid in cycle k+1.
  - All channel forwarding is combinational within the state; there is no added data latency.
  - Back-to-back transactions cost one IDLE cycle each.
- Simultaneous requests from both masters resolve by `last`. A master whose request arrives in the same cycle the other is granted waits for the full transaction.
- `rresp` and `bresp` pass through unmodified. SLVERR/DECERR from the bridge reaches the owner.

## Structure
- Shared package holds the state encoding constants (IDLE, RD_A, RD_D, WR_AW, WR_B, 3-bit) and the AXI resp constants (OKAY = 2'b00, SLVERR = 2'b10).
- One natural sub-module, `rr_arbiter_2`: the 2-requester round-robin grant logic with its `last` register and a grant-enable input.
- The channel multiplexing stays in the top module.

## Test plan
- Master 0 only: read from 0x4000_0000 with a bridge returning 0xA5A5_0001 → master 0 receives rdata 0xA5A5_0001 with rresp OKAY. `grant` is 01 during the transaction; master 1 sees no ready.
- Both masters assert arvalid in the same cycle after reset → master 0 (addr 0x4000_1000) completes first, then master 1 (addr 0x4000_2000). There is one IDLE cycle between them.
- Master 0 holds continuous read requests while master 1 requests once → grants go master 0, master 1, master 0 (strict alternation).
- Master 1 write: wvalid asserted 3 cycles before awvalid, addr 0x4000_3000, data 0x55, wstrb 4'b0001 → the bridge receives one AW and one W. Master 1 gets bresp OKAY and the state returns to IDLE.
- Master 0 asserts awvalid and arvalid together → the write completes first and the read is granted afterwards. With master 1 idle, the read is still granted to master 0.
- Reset asserted during RD_D with rvalid pending → the next cycle shows `busy` 0, `grant` 00 and all readies 0. A new master 1 read after release completes normally.

Source files
------------

// File: rtl/panda_dbus_arbiter_pkg.sv
// panda_dbus_arbiter_pkg
//   Shared definitions for the two-master AXI-Lite data bus arbiter:
//   FSM state encoding (3-bit) and AXI response codes.
package panda_dbus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // True for either error response coming back from the bridge.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/panda_dbus_arbiter_rr_arbiter_2.sv
// rr_arbiter_2
//   Two-requester round-robin grant logic.
//   Ports:
//     clk, rst   system clock, async active-high reset
//     i_req[1:0] request per requester
//     i_en       commit the current winner into the round-robin state
//     o_gnt[1:0] one-hot combinational winner (00 when nobody requests)
//   The requester that did not win last time has priority. r_last resets
//   to 1 so requester 0 wins the first contention.
module rr_arbiter_2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (r_last) begin
            if (i_req[0])      w_gnt = 2'b01;
            else if (i_req[1]) w_gnt = 2'b10;
        end else begin
            if (i_req[1])      w_gnt = 2'b10;
            else if (i_req[0]) w_gnt = 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last <= 1'b1;
        else if (i_en && (|i_req))
            r_last <= w_gnt[1];
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/panda_dbus_arbiter.sv
// panda_dbus_arbiter
//   Shares one AXI-Lite slave path (the AXI-APB bridge) between master 0
//   (core data bus) and master 1 (DMA / debug). Whole transactions are
//   granted round-robin; only one read or write is outstanding at a time.
//   Ports:
//     clk, rst        system clock, async active-high reset
//     s0_axi_*        AXI-Lite slave port for master 0
//     s1_axi_*        AXI-Lite slave port for master 1
//     m_axi_*         AXI-Lite master port toward the bridge (prot tied 0)
//     grant[1:0]      one-hot owner of the current transaction, 00 idle
//     busy            high whenever the FSM is not in IDLE
module panda_dbus_arbiter
    import panda_dbus_arbiter_pkg::*;
#(
    parameter int addr_width       = 32,
    parameter int data_width       = 32,
    parameter int simulation_delay = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    // master 0
    input  logic [addr_width-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [data_width-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready,
    input  logic [addr_width-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [data_width-1:0]   s0_axi_wdata,
    input  logic [data_width/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    // master 1
    input  logic [addr_width-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [data_width-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready,
    input  logic [addr_width-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [data_width-1:0]   s1_axi_wdata,
    input  logic [data_width/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    // toward the bridge
    output logic [addr_width-1:0]   m_axi_araddr,
    output logic [2:0]              m_axi_arprot,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [data_width-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready,
    output logic [addr_width-1:0]   m_axi_awaddr,
    output logic [2:0]              m_axi_awprot,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [data_width-1:0]   m_axi_wdata,
    output logic [data_width/8-1:0] m_axi_wstrb,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [1:0]              m_axi_bresp,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    // status
    output logic [1:0]              grant,
    output logic                    busy
);

    arb_state_t r_state, w_state_nxt;
    logic [1:0] r_grant;
    logic       r_aw_done, r_w_done;

    logic [1:0] w_req, w_win;
    logic       w_win_aw, w_sel;
    logic       w_in_rd_a, w_in_rd_d, w_in_wr_aw, w_in_wr_b;
    logic       w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs, w_wr_addr_data_done;

    // Register updates carry no simulation delay in this implementation;
    // the parameter is kept so existing instantiations still elaborate.
    logic w_unused_sim_delay;
    assign w_unused_sim_delay = (simulation_delay != 0);

    assign w_req = {s1_axi_arvalid | s1_axi_awvalid,
                    s0_axi_arvalid | s0_axi_awvalid};

    rr_arbiter_2 u_rr (
        .clk   (clk),
        .rst   (rst),
        .i_req (w_req),
        .i_en  (r_state == IDLE),
        .o_gnt (w_win)
    );

    // Write wins over read within the winning master.
    assign w_win_aw = w_win[1] ? s1_axi_awvalid : s0_axi_awvalid;

    assign w_sel      = r_grant[1];
    assign w_in_rd_a  = (r_state == RD_A);
    assign w_in_rd_d  = (r_state == RD_D);
    assign w_in_wr_aw = (r_state == WR_AW);
    assign w_in_wr_b  = (r_state == WR_B);

    // ---------------- forwarding toward the bridge ----------------
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_araddr  = w_sel ? s1_axi_araddr : s0_axi_araddr;
    assign m_axi_arvalid = w_in_rd_a & (w_sel ? s1_axi_arvalid : s0_axi_arvalid);
    assign m_axi_rready  = w_in_rd_d & (w_sel ? s1_axi_rready : s0_axi_rready);
    assign m_axi_awaddr  = w_sel ? s1_axi_awaddr : s0_axi_awaddr;
    assign m_axi_wdata   = w_sel ? s1_axi_wdata  : s0_axi_wdata;
    assign m_axi_wstrb   = w_sel ? s1_axi_wstrb  : s0_axi_wstrb;
    // Each of AW/W is presented only until its own handshake.
    assign m_axi_awvalid = w_in_wr_aw & ~r_aw_done & (w_sel ? s1_axi_awvalid : s0_axi_awvalid);
    assign m_axi_wvalid  = w_in_wr_aw & ~r_w_done  & (w_sel ? s1_axi_wvalid  : s0_axi_wvalid);
    assign m_axi_bready  = w_in_wr_b & (w_sel ? s1_axi_bready : s0_axi_bready);

    assign w_ar_hs = m_axi_arvalid & m_axi_arready;
    assign w_r_hs  = m_axi_rready  & m_axi_rvalid;
    assign w_aw_hs = m_axi_awvalid & m_axi_awready;
    assign w_w_hs  = m_axi_wvalid  & m_axi_wready;
    assign w_b_hs  = m_axi_bready  & m_axi_bvalid;
    assign w_wr_addr_data_done = (r_aw_done | w_aw_hs) & (r_w_done | w_w_hs);

    // ---------------- responses back to the owner ----------------
    assign s0_axi_arready = r_grant[0] & w_in_rd_a & m_axi_arready;
    assign s1_axi_arready = r_grant[1] & w_in_rd_a & m_axi_arready;
    assign s0_axi_awready = r_grant[0] & w_in_wr_aw & ~r_aw_done & m_axi_awready;
    assign s1_axi_awready = r_grant[1] & w_in_wr_aw & ~r_aw_done & m_axi_awready;
    assign s0_axi_wready  = r_grant[0] & w_in_wr_aw & ~r_w_done & m_axi_wready;
    assign s1_axi_wready  = r_grant[1] & w_in_wr_aw & ~r_w_done & m_axi_wready;

    assign s0_axi_rdata  = m_axi_rdata;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s0_axi_rvalid = r_grant[0] & w_in_rd_d & m_axi_rvalid;
    assign s1_axi_rvalid = r_grant[1] & w_in_rd_d & m_axi_rvalid;
    assign s0_axi_rresp  = (r_grant[0] & w_in_rd_d) ? m_axi_rresp : RESP_OKAY;
    assign s1_axi_rresp  = (r_grant[1] & w_in_rd_d) ? m_axi_rresp : RESP_OKAY;
    assign s0_axi_bvalid = r_grant[0] & w_in_wr_b & m_axi_bvalid;
    assign s1_axi_bvalid = r_grant[1] & w_in_wr_b & m_axi_bvalid;
    assign s0_axi_bresp  = (r_grant[0] & w_in_wr_b) ? m_axi_bresp : RESP_OKAY;
    assign s1_axi_bresp  = (r_grant[1] & w_in_wr_b) ? m_axi_bresp : RESP_OKAY;

    assign grant = r_grant;
    assign busy  = (r_state != IDLE);

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req)              w_state_nxt = w_win_aw ? WR_AW : RD_A;
            RD_A:    if (w_ar_hs)             w_state_nxt = RD_D;
            RD_D:    if (w_r_hs)              w_state_nxt = IDLE;
            WR_AW:   if (w_wr_addr_data_done) w_state_nxt = WR_B;
            WR_B:    if (w_b_hs)              w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Grant is latched when leaving IDLE and dropped on the way back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant   <= 2'b00;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            if (r_state == IDLE)
                r_grant <= w_win;
            else if (w_state_nxt == IDLE)
                r_grant <= 2'b00;

            if (w_in_wr_aw) begin
                if (w_wr_addr_data_done) begin
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                end else begin
                    r_aw_done <= r_aw_done | w_aw_hs;
                    r_w_done  <= r_w_done  | w_w_hs;
                end
            end
        end
    end

endmodule
